// File: rtl/chess_pkg.sv
// Shared constants for the chess sound path: tone codes, requester slots and
// the sound arbiter state encoding.
package chess_pkg;

    localparam logic [2:0] SND_MOVE     = 3'd1;
    localparam logic [2:0] SND_CAPTURE  = 3'd2;
    localparam logic [2:0] SND_ILLEGAL  = 3'd3;
    localparam logic [2:0] SND_TICK     = 3'd4;
    localparam logic [2:0] SND_WARN     = 3'd5;
    localparam logic [2:0] SND_GAMEOVER = 3'd6;

    // Requester slots, lowest index wins; tick and timer warning share a slot.
    localparam int REQ_GAMEOVER = 0;
    localparam int REQ_MOVE     = 1;
    localparam int REQ_ILLEGAL  = 2;
    localparam int REQ_TICK     = 3;
    localparam int REQ_WARN     = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TONE = 2'd1,
        ST_GAP  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/sound_arbiter_prio_enc.sv
// Fixed-priority encoder: reports the lowest set bit of a pending vector.
module prio_enc #(
    parameter int NREQ = 4,
    parameter int ID_W = 2
) (
    input  logic [NREQ-1:0] pend,
    output logic [ID_W-1:0] idx,
    output logic            vld
);

    always_comb begin
        idx = '0;
        vld = 1'b0;
        // Scan downward so the lowest index is the last one written.
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (pend[i]) begin
                idx = ID_W'(i);
                vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sound_arbiter.sv
// Shares the single tone generator among event sources: latches request
// pulses, plays the highest-priority one for a fixed length, then stays silent.
module sound_arbiter
    import chess_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int CODE_W      = 3,
    parameter int TONE_CYCLES = 12000000,
    parameter int GAP_CYCLES  = 2000000,
    parameter int PREEMPT     = 1,
    localparam int ID_W       = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*CODE_W-1:0] req_code,
    input  logic                   mute,
    output logic [CODE_W-1:0]      sound_code,
    output logic                   play_sound,
    output logic [ID_W-1:0]        grant_id,
    output logic                   busy,
    output logic                   overrun
);

    localparam int CNT_MAX = (TONE_CYCLES > GAP_CYCLES) ? TONE_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] TONE_LOAD = CNT_W'(TONE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

    arb_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NREQ-1:0]     pend_q, pend_d;
    logic [CODE_W-1:0]   code_q [NREQ];
    logic [CODE_W-1:0]   code_d [NREQ];
    logic [CODE_W-1:0]   snd_q, snd_d;
    logic [ID_W-1:0]     gid_q, gid_d;
    logic                play_q, play_d;
    logic                ovr_q, ovr_d;

    logic [ID_W-1:0]     enc_idx;
    logic                enc_vld;
    logic                gnt_vld;
    logic [ID_W-1:0]     gnt_idx;
    logic                preempt;

    prio_enc #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_prio_enc (
        .pend (pend_q),
        .idx  (enc_idx),
        .vld  (enc_vld)
    );

    assign preempt = (PREEMPT != 0) && (state_q == ST_TONE) && pend_q[0] && (gid_q != '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        code_d  = code_q;
        snd_d   = snd_q;
        gid_d   = gid_q;
        play_d  = play_q;
        ovr_d   = 1'b0;
        gnt_vld = 1'b0;
        gnt_idx = '0;

        case (state_q)
            ST_IDLE: begin
                if (enc_vld) begin
                    gnt_vld = 1'b1;
                    gnt_idx = enc_idx;
                end
            end
            ST_TONE: begin
                // Preemption wins over expiry so slot 0 never sees a gap first.
                if (preempt) begin
                    gnt_vld = 1'b1;
                    gnt_idx = '0;
                end else if (cnt_q == '0) begin
                    state_d = ST_GAP;
                    play_d  = 1'b0;
                    cnt_d   = GAP_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (gnt_vld) begin
            state_d         = ST_TONE;
            cnt_d           = TONE_LOAD;
            play_d          = 1'b1;
            snd_d           = code_q[gnt_idx];
            gid_d           = gnt_idx;
            pend_d[gnt_idx] = 1'b0;
        end

        // A request landing on the slot being granted re-arms it rather than overrunning.
        for (int i = 0; i < NREQ; i++) begin
            if (req[i]) begin
                if (pend_q[i] && !(gnt_vld && (gnt_idx == ID_W'(i)))) begin
                    ovr_d = 1'b1;
                end
                pend_d[i] = 1'b1;
                code_d[i] = req_code[i*CODE_W +: CODE_W];
            end
        end

        if (mute) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            pend_d  = '0;
            code_d  = code_q;
            play_d  = 1'b0;
            ovr_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pend_q  <= '0;
            snd_q   <= '0;
            gid_q   <= '0;
            play_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            snd_q   <= snd_d;
            gid_q   <= gid_d;
            play_q  <= play_d;
            ovr_q   <= ovr_d;
        end
    end

    // Stored codes are only meaningful behind a pending bit, so they carry no reset.
    always_ff @(posedge clk) begin
        code_q <= code_d;
    end

    assign sound_code = snd_q;
    assign grant_id   = gid_q;
    assign play_sound = play_q;
    assign overrun    = ovr_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sound_arbiter.sv
// Directed bench for sound_arbiter with short tone/gap lengths (8/3 cycles).
module tb_sound_arbiter;

    logic        clk;
    logic        rstn;
    logic [3:0]  req;
    logic [11:0] req_code;
    logic        mute;
    logic [2:0]  sound_code;
    logic        play_sound;
    logic [1:0]  grant_id;
    logic        busy;
    logic        overrun;

    int checks   = 0;
    int failures = 0;

    sound_arbiter #(
        .NREQ        (4),
        .CODE_W      (3),
        .TONE_CYCLES (8),
        .GAP_CYCLES  (3),
        .PREEMPT     (1)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req        (req),
        .req_code   (req_code),
        .mute       (mute),
        .sound_code (sound_code),
        .play_sound (play_sound),
        .grant_id   (grant_id),
        .busy       (busy),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_req(input int idx, input logic [2:0] code);
        req[idx] = 1'b1;
        req_code[idx*3 +: 3] = code;
        step();
        req = '0;
    endtask

    // Counts consecutive samples with play_sound high, starting at the current one.
    task automatic count_tone(output int n);
        n = 0;
        while (play_sound && n < 100) begin
            n++;
            step();
        end
    endtask

    task automatic count_low(output int n);
        n = 0;
        while (!play_sound && n < 100) begin
            n++;
            step();
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 50) begin
            n++;
            step();
        end
        check("wait_idle_busy", busy, 0);
    endtask

    initial begin
        int n;
        logic seen;
        rstn     = 1'b0;
        req      = '0;
        req_code = '0;
        mute     = 1'b0;
        repeat (3) step();
        check("rst_play", play_sound, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        check("rst_code", sound_code, 0);
        check("rst_gid", grant_id, 0);
        rstn = 1'b1;
        step();

        // Single request: two-cycle latency, 8 tone cycles, busy clears 11 cycles after start
        pulse_req(2, 3'd3);
        check("single_latency_low", play_sound, 0);
        step();
        check("single_play", play_sound, 1);
        check("single_code", sound_code, 3);
        check("single_gid", grant_id, 2);
        count_tone(n);
        check("single_len", n, 8);
        check("single_gap_busy", busy, 1);
        step(); step();
        check("single_gap_end_busy", busy, 1);
        step();
        check("single_busy_fall", busy, 0);
        step();

        // Simultaneous requests: slot 1 first, slot 3 after gap+idle
        req = 4'b1010;
        req_code[3 +: 3] = 3'd1;
        req_code[9 +: 3] = 3'd4;
        step();
        req = '0;
        step();
        check("simul_first_gid", grant_id, 1);
        check("simul_first_code", sound_code, 1);
        count_tone(n);
        check("simul_first_len", n, 8);
        count_low(n);
        check("simul_low_len", n, 4);
        check("simul_second_gid", grant_id, 3);
        check("simul_second_code", sound_code, 4);
        count_tone(n);
        check("simul_second_len", n, 8);
        wait_idle();

        // Overwrite while pending behind a tone: overrun pulses once, latest code plays
        pulse_req(2, 3'd3);
        step();
        pulse_req(3, 3'd4);
        check("ovw_no_overrun_first", overrun, 0);
        pulse_req(3, 3'd5);
        check("ovw_overrun", overrun, 1);
        step();
        check("ovw_overrun_once", overrun, 0);
        count_tone(n);
        check("ovw_rest_len", n, 5);
        count_low(n);
        check("ovw_low_len", n, 4);
        check("ovw_code", sound_code, 5);
        check("ovw_gid", grant_id, 3);
        count_tone(n);
        wait_idle();

        // Request on the slot being granted: old code plays, new one stays pending, no overrun
        pulse_req(3, 3'd4);
        pulse_req(3, 3'd5);
        check("sameslot_overrun", overrun, 0);
        check("sameslot_code", sound_code, 4);
        count_tone(n);
        count_low(n);
        check("sameslot_low_len", n, 4);
        check("sameslot_second_code", sound_code, 5);
        count_tone(n);
        wait_idle();

        // Preemption by slot 0; slot 0 itself is not preempted
        pulse_req(2, 3'd3);
        step();
        step();
        pulse_req(0, 3'd6);
        check("pre_before_code", sound_code, 3);
        step();
        check("pre_play_held", play_sound, 1);
        check("pre_code", sound_code, 6);
        check("pre_gid", grant_id, 0);
        pulse_req(0, 3'd1);
        check("pre_noself_code", sound_code, 6);
        count_tone(n);
        check("pre_rest_len", n, 7);
        count_low(n);
        check("pre_queued0_low", n, 4);
        check("pre_queued0_code", sound_code, 1);
        check("pre_queued0_gid", grant_id, 0);
        count_tone(n);
        check("pre_queued0_len", n, 8);
        wait_idle();
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            seen = seen | play_sound;
        end
        check("pre_no_replay", seen, 0);

        // Mute mid-tone flushes pending slot 1
        pulse_req(2, 3'd3);
        step();
        pulse_req(1, 3'd1);
        mute = 1'b1;
        step();
        mute = 1'b0;
        check("mute_play", play_sound, 0);
        check("mute_busy", busy, 0);
        check("mute_overrun", overrun, 0);
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step();
            seen = seen | play_sound;
        end
        check("mute_no_later_tone", seen, 0);
        mute = 1'b1;
        req[3] = 1'b1;
        req_code[9 +: 3] = 3'd4;
        step();
        mute = 1'b0;
        req = '0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            seen = seen | play_sound | busy;
        end
        check("mute_ignores_req", seen, 0);

        // Asynchronous reset during GAP
        pulse_req(2, 3'd3);
        step();
        count_tone(n);
        check("areset_pre_busy", busy, 1);
        #2;
        rstn = 1'b0;
        #1;
        check("areset_busy", busy, 0);
        check("areset_play", play_sound, 0);
        check("areset_code", sound_code, 0);
        check("areset_gid", grant_id, 0);
        rstn = 1'b1;
        step();
        pulse_req(1, 3'd2);
        check("areset_latency_low", play_sound, 0);
        step();
        check("areset_play_after", play_sound, 1);
        check("areset_code_after", sound_code, 2);
        check("areset_gid_after", grant_id, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
